// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, common command
// bytes and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_RESET        = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE       = 8'hF4;
    localparam logic [7:0] PS2_CMD_SET_DEFAULTS = 8'hF6;
    localparam logic [7:0] PS2_ACK_BYTE         = 8'hFA;

    // Odd parity bit: makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and completion status between the init logic and the
// PS/2 host transmitter.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err_timeout;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_ok, err_timeout
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_ok, err_timeout
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pin plus a falling-edge
// detector on the synchronized level. Idle bus level is high, so the flops
// reset to 1 to avoid a false edge after reset.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    output logic level,
    output logic fall
);

    logic [1:0] sync_r;
    logic       prev_r;

    // Shift the raw pin through two flops and keep the previous synced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b11;
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[0], pin_in};
            prev_r <= sync_r[1];
        end
    end

    assign level = sync_r[1];
    assign fall  = prev_r & ~sync_r[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then
// shifts start/data/parity/stop on device-generated clock falls and collects
// the device ACK. Pins are driven only through open-drain enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);
    import ps2_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e    state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       bitn_r, bitn_s;
    logic [7:0]       byte_r, byte_s;
    logic             ack_seen_r, ack_seen_s;
    logic             clk_oe_r, clk_oe_s;
    logic             data_oe_r, data_oe_s;
    logic             busy_r, busy_s;
    logic             ready_r, ready_s;
    logic             done_r, done_s;
    logic             ack_ok_r, ack_ok_s;
    logic             err_r, err_s;

    logic clk_lvl_s, clk_fall_s;
    logic data_lvl_s, data_fall_unused_s;
    logic tmo_s;

    ps2_sync_edge u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_in (ps2_clk_in),
        .level  (clk_lvl_s),
        .fall   (clk_fall_s)
    );

    // Data edges matter only to the receive path; the host samples levels.
    ps2_sync_edge u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_in (ps2_data_in),
        .level  (data_lvl_s),
        .fall   (data_fall_unused_s)
    );

    assign tmo_s = ((state_r == SEND) || (state_r == ACK) || (state_r == WAIT_IDLE))
                   && (cnt_r == TMO_LAST);

    // Next-state and next-output logic; timeout outranks any device event.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bitn_s     = bitn_r;
        byte_s     = byte_r;
        ack_seen_s = ack_seen_r;
        clk_oe_s   = clk_oe_r;
        data_oe_s  = data_oe_r;
        busy_s     = busy_r;
        ready_s    = ready_r;
        done_s     = 1'b0;
        ack_ok_s   = 1'b0;
        err_s      = 1'b0;
        if (tmo_s) begin
            state_s   = IDLE;
            cnt_s     = '0;
            clk_oe_s  = 1'b0;
            data_oe_s = 1'b0;
            busy_s    = 1'b0;
            ready_s   = 1'b1;
            done_s    = 1'b1;
            err_s     = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    clk_oe_s  = 1'b0;
                    data_oe_s = 1'b0;
                    cnt_s     = '0;
                    if (bus.tx_valid && ready_r) begin
                        state_s    = INHIBIT;
                        byte_s     = bus.tx_data;
                        ack_seen_s = 1'b0;
                        busy_s     = 1'b1;
                        ready_s    = 1'b0;
                        clk_oe_s   = 1'b1;
                    end else begin
                        busy_s  = 1'b0;
                        ready_s = 1'b1;
                    end
                end
                INHIBIT: begin
                    clk_oe_s = 1'b1;
                    if (cnt_r == INH_LAST) begin
                        state_s   = RTS;
                        cnt_s     = '0;
                        data_oe_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                RTS: begin
                    if (cnt_r == RTS_LAST) begin
                        state_s  = SEND;
                        cnt_s    = '0;
                        bitn_s   = 4'd0;
                        clk_oe_s = 1'b0;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                SEND: begin
                    cnt_s    = cnt_r + CNT_ONE;
                    clk_oe_s = 1'b0;
                    if (clk_fall_s) begin
                        bitn_s = bitn_r + 4'd1;
                        if (bitn_r < 4'd8) begin
                            data_oe_s = ~byte_r[bitn_r[2:0]];
                        end else if (bitn_r == 4'd8) begin
                            data_oe_s = ~odd_parity(byte_r);
                        end else begin
                            data_oe_s = 1'b0;
                            state_s   = ACK;
                        end
                    end else begin
                        bitn_s = bitn_r;
                    end
                end
                ACK: begin
                    cnt_s     = cnt_r + CNT_ONE;
                    data_oe_s = 1'b0;
                    if (clk_fall_s) begin
                        ack_seen_s = ~data_lvl_s;
                        state_s    = WAIT_IDLE;
                    end else begin
                        ack_seen_s = ack_seen_r;
                    end
                end
                WAIT_IDLE: begin
                    cnt_s = cnt_r + CNT_ONE;
                    if (clk_lvl_s && data_lvl_s) begin
                        state_s  = IDLE;
                        cnt_s    = '0;
                        done_s   = 1'b1;
                        ack_ok_s = ack_seen_r;
                        busy_s   = 1'b0;
                        ready_s  = 1'b1;
                    end else begin
                        state_s = WAIT_IDLE;
                    end
                end
                default: begin
                    state_s   = IDLE;
                    cnt_s     = '0;
                    clk_oe_s  = 1'b0;
                    data_oe_s = 1'b0;
                    busy_s    = 1'b0;
                    ready_s   = 1'b1;
                end
            endcase
        end
    end

    // State, counter, latched byte and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            bitn_r     <= 4'd0;
            byte_r     <= 8'h00;
            ack_seen_r <= 1'b0;
            clk_oe_r   <= 1'b0;
            data_oe_r  <= 1'b0;
            busy_r     <= 1'b0;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            ack_ok_r   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bitn_r     <= bitn_s;
            byte_r     <= byte_s;
            ack_seen_r <= ack_seen_s;
            clk_oe_r   <= clk_oe_s;
            data_oe_r  <= data_oe_s;
            busy_r     <= busy_s;
            ready_r    <= ready_s;
            done_r     <= done_s;
            ack_ok_r   <= ack_ok_s;
            err_r      <= err_s;
        end
    end

    assign ps2_clk_oe      = clk_oe_r;
    assign ps2_data_oe     = data_oe_r;
    assign bus.tx_ready    = ready_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.ack_ok      = ack_ok_r;
    assign bus.err_timeout = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out of the
// host on a wired-AND bus and optionally acknowledges; frames are compared
// against a reference built from start/data/odd-parity/stop rules.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int RTSC = 4;
    localparam int TMO  = 3000;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_oe, ps2_data_oe;
    logic ps2_clk_line, ps2_data_line;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int inh_cnt  = 0;
    int rts_cnt  = 0;
    logic [10:0] frame;

    ps2_host_tx_if bus();

    assign ps2_clk_line  = ~(ps2_clk_oe  | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTSC),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    // Count done pulses and the host-driven inhibit / request-to-send cycles.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inh_cnt++;
        if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) rts_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame, index k = k-th bit on the wire: start, d0..d7, parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    // Device: waits for request-to-send, then generates clock pulses, sampling
    // the data line late in each high phase; optionally ACKs on the 11th clock.
    task automatic device_run(input int pulses, input bit give_ack);
        int t = 0;
        frame = '1;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("dev_rts_wait", 32'(t < 400), 32'd1);
        for (int k = 0; k < pulses; k++) begin
            repeat (HALF - 5) @(negedge clk);
            frame[k] = ps2_data_line;
            if (k == 10 && give_ack) dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        if (give_ack) begin
            repeat (5) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic start_tx(input logic [7:0] b);
        int t = 0;
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        while (bus.tx_ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", 32'(t < 5000), 32'd1);
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output logic ack,
                             output logic err, output logic rdy);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("done_wait", 32'(cyc < budget), 32'd1);
        ack = bus.ack_ok;
        err = bus.err_timeout;
        rdy = bus.tx_ready;
    endtask

    initial begin
        int cyc, t, d0;
        logic ack, err, rdy, ack2, err2;
        logic [10:0] f1, exp_f;
        logic [7:0] rb;
        bit ra;

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ack_ok", bus.ack_ok, 0);
        check("rst_err", bus.err_timeout, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 0xF4 with ACK
        inh_cnt = 0;
        rts_cnt = 0;
        fork
            device_run(11, 1'b1);
            begin
                start_tx(8'hF4);
                wait_done(4000, cyc, ack, err, rdy);
            end
        join
        check("f4_inhibit_cycles", inh_cnt, INH);
        check("f4_rts_cycles", rts_cnt, RTSC);
        check("f4_frame", 32'(frame), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
        check("f4_ack_ok", ack, 1);
        check("f4_err", err, 0);
        check("f4_ready_with_done", rdy, 1);
        @(negedge clk);
        check("f4_done_one_cycle", bus.done, 0);
        check("f4_busy_clear", bus.busy, 0);

        // 0x00 without ACK: parity 1, NACK
        fork
            device_run(11, 1'b0);
            begin
                start_tx(8'h00);
                wait_done(4000, cyc, ack, err, rdy);
            end
        join
        check("nack_frame", 32'(frame), 32'(ref_frame(8'h00)));
        check("nack_par", 32'(frame[9]), 32'd1);
        check("nack_ack_ok", ack, 0);
        check("nack_err", err, 0);

        // Device never clocks: timeout counted from clk release
        start_tx(8'hA5);
        t = 0;
        while (ps2_clk_oe !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("tmo_release_wait", 32'(t < 200), 32'd1);
        wait_done(4000, cyc, ack, err, rdy);
        check("tmo_cycles", cyc, TMO);
        check("tmo_err", err, 1);
        check("tmo_ack_ok", ack, 0);
        check("tmo_clk_oe", ps2_clk_oe, 0);
        check("tmo_data_oe", ps2_data_oe, 0);
        check("tmo_ready", rdy, 1);
        repeat (5) @(negedge clk);

        // tx_valid held high with a new byte during the transfer
        d0 = done_cnt;
        fork
            device_run(11, 1'b1);
            begin
                bus.tx_data  = 8'hF4;
                bus.tx_valid = 1'b1;
                @(negedge clk);
                bus.tx_data = 8'hFF;
                wait_done(4000, cyc, ack, err, rdy);
                bus.tx_valid = 1'b0;
            end
        join
        repeat (100) @(negedge clk);
        check("hold_done_count", done_cnt - d0, 1);
        check("hold_frame", 32'(frame), 32'(ref_frame(8'hF4)));
        check("hold_ack_ok", ack, 1);
        check("hold_busy", bus.busy, 0);

        // Reset during SEND after the 5th device clock
        fork
            device_run(5, 1'b0);
            start_tx(8'h00);
        join
        exp_f = ref_frame(8'h00);
        check("mid_partial_frame", 32'(frame[4:0]), 32'(exp_f[4:0]));
        check("mid_data_oe_bit4", ps2_data_oe, 1);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_clk_oe", ps2_clk_oe, 0);
        check("mid_rst_data_oe", ps2_data_oe, 0);
        check("mid_rst_ready", bus.tx_ready, 1);
        check("mid_rst_done", bus.done, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_rst_no_done", done_cnt - d0, 0);
        fork
            device_run(11, 1'b1);
            begin
                start_tx(8'hFF);
                wait_done(4000, cyc, ack, err, rdy);
            end
        join
        check("post_rst_frame", 32'(frame), 32'(ref_frame(8'hFF)));
        check("post_rst_ack_ok", ack, 1);
        repeat (3) @(negedge clk);

        // Back-to-back: second request raised on the done cycle
        fork
            begin
                device_run(11, 1'b1);
                f1 = frame;
                device_run(11, 1'b1);
            end
            begin
                start_tx(8'hFF);
                wait_done(4000, cyc, ack, err, rdy);
                check("b2b_ready_at_done", rdy, 1);
                bus.tx_data  = 8'hF4;
                bus.tx_valid = 1'b1;
                @(negedge clk);
                bus.tx_valid = 1'b0;
                check("b2b_accepted_ready", bus.tx_ready, 0);
                check("b2b_accepted_busy", bus.busy, 1);
                wait_done(4000, cyc, ack2, err2, rdy);
            end
        join
        check("b2b_frame1", 32'(f1), 32'(ref_frame(8'hFF)));
        check("b2b_frame2", 32'(frame), 32'(ref_frame(8'hF4)));
        check("b2b_ack1", ack, 1);
        check("b2b_ack2", ack2, 1);
        check("b2b_err2", err2, 0);
        repeat (3) @(negedge clk);

        // Random bytes with random device ACK behaviour
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom_range(0, 255));
            ra = 1'($urandom_range(0, 1));
            fork
                device_run(11, ra);
                begin
                    start_tx(rb);
                    wait_done(4000, cyc, ack, err, rdy);
                end
            join
            check("rand_frame", 32'(frame), 32'(ref_frame(rb)));
            check("rand_ack_ok", ack, 32'(ra));
            check("rand_err", err, 0);
            repeat (3) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
